pipelined_instruction_decoder: RTL

- Decode stage for the RISC pipeline, sitting between instruction fetch (IR) and register-file/ALU stage.
- Converts each 32-bit instruction into a registered control word, with a valid/ready handshake on both sides and a one-entry skid buffer.
- Parametrised register-address width, link register and illegal-opcode counter width.
- Supports pipeline flush and flags undefined opcodes.

---
 rtl/decoder_pkg.sv | 67 ++++++
 rtl/instruction_decode_comb.sv | 117 +++++++++++
 rtl/pipelined_instruction_decoder.sv | 134 +++++++++++++
 3 files changed

// File: rtl/decoder_pkg.sv
// Shared definitions for the decode stage: opcodes, field encodings and control word layout.
package decoder_pkg;

  localparam int OPC_W = 7;

  // Register-to-register ALU operations
  localparam logic [6:0] OP_NOP = 7'b0000000;
  localparam logic [6:0] OP_ADD = 7'b0000010;
  localparam logic [6:0] OP_SUB = 7'b0000101;
  localparam logic [6:0] OP_SLT = 7'b1100101;
  localparam logic [6:0] OP_AND = 7'b0001000;
  localparam logic [6:0] OP_OR  = 7'b0001010;
  localparam logic [6:0] OP_XOR = 7'b0001100;

  // Memory and immediate operations
  localparam logic [6:0] OP_ST  = 7'b0000001;
  localparam logic [6:0] OP_LD  = 7'b0100001;
  localparam logic [6:0] OP_ADI = 7'b0100010;
  localparam logic [6:0] OP_SBI = 7'b0100101;
  localparam logic [6:0] OP_NOT = 7'b0101110;
  localparam logic [6:0] OP_ANI = 7'b0101000;
  localparam logic [6:0] OP_ORI = 7'b0101010;
  localparam logic [6:0] OP_XRI = 7'b0101100;

  // Unsigned immediates, moves and shifts
  localparam logic [6:0] OP_AIU = 7'b1100010;
  localparam logic [6:0] OP_SIU = 7'b1000101;
  localparam logic [6:0] OP_MOV = 7'b1000000;
  localparam logic [6:0] OP_LSL = 7'b0110000;
  localparam logic [6:0] OP_LSR = 7'b0110001;

  // Control transfer
  localparam logic [6:0] OP_JMR = 7'b1100001;
  localparam logic [6:0] OP_BZ  = 7'b0100000;
  localparam logic [6:0] OP_BNZ = 7'b1100000;
  localparam logic [6:0] OP_JMP = 7'b1000100;
  localparam logic [6:0] OP_JML = 7'b0000111;

  // MD: selects what is written back to the register file
  localparam logic [1:0] MD_ALU = 2'b00;
  localparam logic [1:0] MD_MEM = 2'b01;
  localparam logic [1:0] MD_SLT = 2'b10;

  // BS: branch select for the PC logic
  localparam logic [1:0] BS_NONE = 2'b00;
  localparam logic [1:0] BS_COND = 2'b01;
  localparam logic [1:0] BS_JUMP = 2'b10;
  localparam logic [1:0] BS_REG  = 2'b11;

  // FS overrides for shifts; all other opcodes use opcode[4:0]
  localparam logic [4:0] FS_LSL = 5'b10100;
  localparam logic [4:0] FS_LSR = 5'b11000;

  // Control word without register addresses, whose width is a parameter of the stage
  typedef struct packed {
    logic       rw;
    logic [1:0] md;
    logic [1:0] bs;
    logic       ps;
    logic       mw;
    logic [4:0] fs;
    logic       ma;
    logic       mb;
    logic       cs;
  } ctrl_t;

endpackage

// File: rtl/instruction_decode_comb.sv
// Purely combinational opcode to control-word mapping with undefined-opcode detection.
module instruction_decode_comb
  import decoder_pkg::*;
#(
  parameter int                IR_W     = 32,
  parameter int                REG_AW   = 4,
  parameter logic [REG_AW-1:0] LINK_REG = {REG_AW{1'b1}}
) (
  input  logic [IR_W-1:0]   i_instr,
  output ctrl_t             o_ctrl,
  output logic [REG_AW-1:0] o_da,
  output logic [REG_AW-1:0] o_aa,
  output logic [REG_AW-1:0] o_ba,
  output logic              o_illegal
);

  logic [OPC_W-1:0]  w_opcode;
  logic [REG_AW-1:0] w_dr;
  logic [REG_AW-1:0] w_sa;
  logic [REG_AW-1:0] w_sb;
  logic              w_unusedBits;

  assign w_opcode     = i_instr[IR_W-1 -: OPC_W];
  assign w_dr         = i_instr[IR_W-8 -: REG_AW];
  assign w_sa         = i_instr[IR_W-8-REG_AW -: REG_AW];
  assign w_sb         = i_instr[IR_W-8-2*REG_AW -: REG_AW];
  assign w_unusedBits = ^i_instr[IR_W-8-3*REG_AW:0];

  // Map the opcode to control fields; anything unlisted collapses to an all-zero NOP word
  always_comb begin
    o_ctrl    = '0;
    o_ctrl.fs = w_opcode[4:0];
    o_illegal = 1'b0;
    case (w_opcode)
      OP_NOP: begin
      end
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_NOT, OP_MOV: begin
        o_ctrl.rw = 1'b1;
      end
      OP_SLT: begin
        o_ctrl.rw = 1'b1;
        o_ctrl.md = MD_SLT;
      end
      OP_ST: begin
        o_ctrl.mw = 1'b1;
      end
      OP_LD: begin
        o_ctrl.rw = 1'b1;
        o_ctrl.md = MD_MEM;
      end
      OP_ADI, OP_SBI: begin
        o_ctrl.rw = 1'b1;
        o_ctrl.mb = 1'b1;
        o_ctrl.cs = 1'b1;
      end
      OP_ANI, OP_ORI, OP_XRI, OP_AIU, OP_SIU: begin
        o_ctrl.rw = 1'b1;
        o_ctrl.mb = 1'b1;
      end
      OP_LSL: begin
        o_ctrl.rw = 1'b1;
        o_ctrl.mb = 1'b1;
        o_ctrl.fs = FS_LSL;
      end
      OP_LSR: begin
        o_ctrl.rw = 1'b1;
        o_ctrl.mb = 1'b1;
        o_ctrl.fs = FS_LSR;
      end
      OP_JMR: begin
        o_ctrl.bs = BS_REG;
      end
      OP_BZ: begin
        o_ctrl.bs = BS_COND;
        o_ctrl.mb = 1'b1;
        o_ctrl.cs = 1'b1;
      end
      OP_BNZ: begin
        o_ctrl.bs = BS_COND;
        o_ctrl.ps = 1'b1;
        o_ctrl.mb = 1'b1;
        o_ctrl.cs = 1'b1;
      end
      OP_JMP: begin
        o_ctrl.bs = BS_JUMP;
        o_ctrl.mb = 1'b1;
        o_ctrl.cs = 1'b1;
      end
      OP_JML: begin
        o_ctrl.rw = 1'b1;
        o_ctrl.bs = BS_JUMP;
        o_ctrl.ma = 1'b1;
        o_ctrl.mb = 1'b1;
        o_ctrl.cs = 1'b1;
      end
      default: begin
        o_ctrl    = '0;
        o_illegal = 1'b1;
      end
    endcase
  end

  // Register addresses: DA only meaningful when writing back, JML always links into LINK_REG
  always_comb begin
    o_da = '0;
    o_aa = '0;
    o_ba = '0;
    if (!o_illegal) begin
      o_aa = w_sa;
      o_ba = w_sb;
      if (o_ctrl.rw) begin
        o_da = (w_opcode == OP_JML) ? LINK_REG : w_dr;
      end
    end
  end

endmodule

// File: rtl/pipelined_instruction_decoder.sv
// Decode stage: registered control word, valid/ready on both sides, one-entry skid buffer.
module pipelined_instruction_decoder
  import decoder_pkg::*;
#(
  parameter int                IR_W     = 32,
  parameter int                REG_AW   = 4,
  parameter logic [REG_AW-1:0] LINK_REG = {REG_AW{1'b1}},
  parameter int                CNT_W    = 8
) (
  input  logic              CLK,
  input  logic              RESET_N,
  input  logic [IR_W-1:0]   IR_instruction,
  input  logic              IR_VALID,
  output logic              IR_READY,
  input  logic              FLUSH,
  output logic              DEC_VALID,
  input  logic              DEC_READY,
  output logic              RW,
  output logic [1:0]        MD,
  output logic [1:0]        BS,
  output logic              PS,
  output logic              MW,
  output logic [4:0]        FS,
  output logic              MA,
  output logic              MB,
  output logic              CS,
  output logic [REG_AW-1:0] DA,
  output logic [REG_AW-1:0] AA,
  output logic [REG_AW-1:0] BA,
  output logic              ILLEGAL,
  output logic [CNT_W-1:0]  ILL_CNT
);

  logic              r_irReady;
  logic              r_outValid;
  ctrl_t             r_ctrl;
  logic [REG_AW-1:0] r_da;
  logic [REG_AW-1:0] r_aa;
  logic [REG_AW-1:0] r_ba;
  logic              r_illegal;
  logic              r_skidFull;
  logic [IR_W-1:0]   r_skidInstr;
  logic [CNT_W-1:0]  r_illCnt;

  logic              w_accept;
  logic              w_outFree;
  logic [IR_W-1:0]   w_srcInstr;
  ctrl_t             w_ctrl;
  logic [REG_AW-1:0] w_da;
  logic [REG_AW-1:0] w_aa;
  logic [REG_AW-1:0] w_ba;
  logic              w_illegal;

  // IR_READY is only high while the skid is empty, so an accept never coincides with a full skid
  assign w_accept   = IR_VALID & r_irReady;
  assign w_outFree  = ~r_outValid | DEC_READY;
  assign w_srcInstr = r_skidFull ? r_skidInstr : IR_instruction;

  instruction_decode_comb #(
    .IR_W     (IR_W),
    .REG_AW   (REG_AW),
    .LINK_REG (LINK_REG)
  ) u_decode (
    .i_instr   (w_srcInstr),
    .o_ctrl    (w_ctrl),
    .o_da      (w_da),
    .o_aa      (w_aa),
    .o_ba      (w_ba),
    .o_illegal (w_illegal)
  );

  // Output register and skid buffer; the skid entry always drains before new input to keep order
  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      r_irReady   <= 1'b0;
      r_outValid  <= 1'b0;
      r_ctrl      <= '0;
      r_da        <= '0;
      r_aa        <= '0;
      r_ba        <= '0;
      r_illegal   <= 1'b0;
      r_skidFull  <= 1'b0;
      r_skidInstr <= '0;
    end else if (FLUSH) begin
      r_outValid <= 1'b0;
      r_skidFull <= 1'b0;
      r_irReady  <= 1'b1;
    end else if (w_outFree) begin
      if (r_skidFull || w_accept) begin
        r_ctrl     <= w_ctrl;
        r_da       <= w_da;
        r_aa       <= w_aa;
        r_ba       <= w_ba;
        r_illegal  <= w_illegal;
        r_outValid <= 1'b1;
      end else begin
        r_outValid <= 1'b0;
      end
      r_skidFull <= 1'b0;
      r_irReady  <= 1'b1;
    end else if (w_accept) begin
      r_skidInstr <= IR_instruction;
      r_skidFull  <= 1'b1;
      r_irReady   <= 1'b0;
    end
  end

  // Saturating count of undefined opcodes accepted outside a flush
  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      r_illCnt <= '0;
    end else if (!FLUSH && w_accept && w_illegal && (r_illCnt != {CNT_W{1'b1}})) begin
      r_illCnt <= r_illCnt + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  assign IR_READY  = r_irReady;
  assign DEC_VALID = r_outValid;
  assign RW        = r_ctrl.rw;
  assign MD        = r_ctrl.md;
  assign BS        = r_ctrl.bs;
  assign PS        = r_ctrl.ps;
  assign MW        = r_ctrl.mw;
  assign FS        = r_ctrl.fs;
  assign MA        = r_ctrl.ma;
  assign MB        = r_ctrl.mb;
  assign CS        = r_ctrl.cs;
  assign DA        = r_da;
  assign AA        = r_aa;
  assign BA        = r_ba;
  assign ILLEGAL   = r_illegal;
  assign ILL_CNT   = r_illCnt;

endmodule
